// File: rtl/program_sequencer.sv
// program_sequencer: owns the program counter and feeds opcodes to the decoder.
// It picks the next PC from the decoder redirects (jump, bzero, bnegative,
// mainAddress, HLT) and the registered ALU flags. It also runs the
// input-instruction handshake with the keypad front end.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   instruction        instruction memory word at pc
//   jump/bzero/bnegative/mainAddress/HLT/flagEnable   decoder controls
//   zero, negative     ALU result flags
//   inputValid         front end holds a value for the input instruction
//   resume             leave HALTED
//   pc                 instruction memory address (registered)
//   operation          opcode to decoder (combinational from instruction)
//   instructionValid   current instruction commits this cycle
//   inputAck           input instruction commits this cycle
//   stall              PC held waiting for input
//   halted             sequencer in HALTED state (registered)
//   retiredCount       committed-instruction counter
//
// Optional feature macro: SEQ_RETIRE_COUNT_EN. When it is defined,
// retiredCount is a saturating commit counter. When it is undefined,
// retiredCount is tied to 0.
module program_sequencer #(
  parameter int unsigned           ADDR_WIDTH   = 10,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [5:0]            OP_IN        = 6'b011101,
  parameter logic [5:0]            OP_NOP       = 6'b011011
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           instruction,
  input  logic                  jump,
  input  logic                  bzero,
  input  logic                  bnegative,
  input  logic [ADDR_WIDTH-1:0] mainAddress,
  input  logic                  HLT,
  input  logic                  flagEnable,
  input  logic                  zero,
  input  logic                  negative,
  input  logic                  inputValid,
  input  logic                  resume,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [5:0]            operation,
  output logic                  instructionValid,
  output logic                  inputAck,
  output logic                  stall,
  output logic                  halted,
  output logic [31:0]           retiredCount
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  zero_flag_q, zero_flag_d;
  logic                  neg_flag_q, neg_flag_d;
  logic                  input_armed_q, input_armed_d;
  logic                  halted_q;
  logic                  commit;
  logic                  is_input;
  logic                  branch_taken;

  // Only the opcode field is used here; the decoder consumes the rest.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[25:0];

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_BOOT;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == S_HALTED);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:   state_d = S_RUN;
      S_RUN:    if (commit && HLT) state_d = S_HALTED;
      S_HALTED: if (resume) state_d = S_RUN;
      default:  state_d = S_BOOT;
    endcase
  end

  // Output logic: opcode presentation, commit decision and handshake strobes
  always_comb begin
    operation        = OP_NOP;
    is_input         = 1'b0;
    commit           = 1'b0;
    instructionValid = 1'b0;
    inputAck         = 1'b0;
    stall            = 1'b0;
    if (state_q == S_RUN) begin
      operation        = instruction[31:26];
      is_input         = (instruction[31:26] == OP_IN);
      // An input instruction needs a fresh keypress (valid and re-armed).
      commit           = !is_input || (inputValid && input_armed_q);
      instructionValid = commit;
      inputAck         = commit && is_input;
      stall            = !commit;
    end
  end

  // Branches test flags captured by earlier instructions.
  assign branch_taken = (bzero && zero_flag_q) || (bnegative && neg_flag_q);

  // Datapath next values: PC, flags, input arming
  always_comb begin
    pc_d          = pc_q;
    zero_flag_d   = zero_flag_q;
    neg_flag_d    = neg_flag_q;
    input_armed_d = input_armed_q;

    if (commit) begin
      if (HLT) begin
        pc_d = pc_q;
      end else if (jump || branch_taken) begin
        pc_d = mainAddress;
      end else begin
        pc_d = pc_q + ADDR_WIDTH'(1);
      end
      if (flagEnable) begin
        zero_flag_d = zero;
        neg_flag_d  = negative;
      end
    end else if (state_q == S_HALTED && resume) begin
      pc_d = pc_q + ADDR_WIDTH'(1);
    end

    // A committed input consumes the keypress; release of the key re-arms.
    if (commit && is_input) begin
      input_armed_d = 1'b0;
    end else if (!inputValid) begin
      input_armed_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_VECTOR;
      zero_flag_q   <= 1'b0;
      neg_flag_q    <= 1'b0;
      input_armed_q <= 1'b1;
    end else begin
      pc_q          <= pc_d;
      zero_flag_q   <= zero_flag_d;
      neg_flag_q    <= neg_flag_d;
      input_armed_q <= input_armed_d;
    end
  end

  assign pc     = pc_q;
  assign halted = halted_q;

`ifdef SEQ_RETIRE_COUNT_EN
  logic [31:0] retired_q, retired_d;

  // Saturating commit counter
  always_comb begin
    retired_d = retired_q;
    if (commit && (retired_q != 32'hFFFF_FFFF)) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_q <= 32'd0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retiredCount = retired_q;
`else
  assign retiredCount = 32'd0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer. The bench models the
// instruction memory as an array read at pc and drives the decoder controls.
module tb_program_sequencer;

  localparam logic [5:0]  OP_IN   = 6'b011101;
  localparam logic [5:0]  OP_NOP  = 6'b011011;
  localparam logic [5:0]  OP_ADD  = 6'b000001;
  localparam logic [31:0] W_ADD   = {OP_ADD, 26'd0};
  localparam logic [31:0] W_IN    = {OP_IN, 26'd0};
`ifdef SEQ_RETIRE_COUNT_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  logic        clock, reset;
  logic [31:0] instruction;
  logic        jump, bzero, bnegative, HLT, flagEnable, zero, negative;
  logic        inputValid, resume;
  logic [9:0]  mainAddress;
  logic [9:0]  pc;
  logic [5:0]  operation;
  logic        instructionValid, inputAck, stall, halted;
  logic [31:0] retiredCount;

  logic [31:0] imem [0:1023];
  int checks;
  int errors;

  assign instruction = imem[pc];

  program_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .instruction      (instruction),
    .jump             (jump),
    .bzero            (bzero),
    .bnegative        (bnegative),
    .mainAddress      (mainAddress),
    .HLT              (HLT),
    .flagEnable       (flagEnable),
    .zero             (zero),
    .negative         (negative),
    .inputValid       (inputValid),
    .resume           (resume),
    .pc               (pc),
    .operation        (operation),
    .instructionValid (instructionValid),
    .inputAck         (inputAck),
    .stall            (stall),
    .halted           (halted),
    .retiredCount     (retiredCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++; if (pc !== 10'd0) begin errors++; $display("FAIL reset_pc got %0d exp 0", pc); end
    checks++; if (operation !== OP_NOP) begin errors++; $display("FAIL reset_op got %b exp %b", operation, OP_NOP); end
    checks++; if ({instructionValid, inputAck, stall, halted} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got %b exp 0000", {instructionValid, inputAck, stall, halted}); end
    checks++; if (retiredCount !== 32'd0) begin errors++; $display("FAIL reset_retired got %0d exp 0", retiredCount); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    // BOOT cycle: no commit, NOP presented, pc at reset vector
    checks++; if (pc !== 10'd0 || instructionValid !== 1'b0 || operation !== OP_NOP) begin
      errors++; $display("FAIL boot_cycle got pc=%0d iv=%b op=%b exp pc=0 iv=0 op=%b", pc, instructionValid, operation, OP_NOP); end
    step();
    checks++; if (pc !== 10'd0 || instructionValid !== 1'b1 || operation !== OP_ADD) begin
      errors++; $display("FAIL run_first got pc=%0d iv=%b op=%b exp pc=0 iv=1 op=%b", pc, instructionValid, operation, OP_ADD); end
    step();
    checks++; if (pc !== 10'd1) begin errors++; $display("FAIL seq_pc1 got %0d exp 1", pc); end
    step();
    checks++; if (pc !== 10'd2) begin errors++; $display("FAIL seq_pc2 got %0d exp 2", pc); end
  endtask

  task automatic test_wrap();
    jump = 1'b1; mainAddress = 10'd1023;
    step();
    checks++; if (pc !== 10'd1023) begin errors++; $display("FAIL jump_1023 got %0d exp 1023", pc); end
    jump = 1'b0;
    step();
    checks++; if (pc !== 10'd0) begin errors++; $display("FAIL wrap_pc got %0d exp 0", pc); end
  endtask

  task automatic test_branch();
    flagEnable = 1'b1; zero = 1'b1; negative = 1'b0;
    step();
    flagEnable = 1'b0; zero = 1'b0; bzero = 1'b1; mainAddress = 10'd40;
    step();
    checks++; if (pc !== 10'd40) begin errors++; $display("FAIL bz_taken got %0d exp 40", pc); end
    flagEnable = 1'b1; zero = 1'b0; bzero = 1'b0;
    step();
    flagEnable = 1'b0; bzero = 1'b1;
    step();
    checks++; if (pc !== 10'd42) begin errors++; $display("FAIL bz_not_taken got %0d exp 42", pc); end
    // Branch that also captures flags uses the old (clear) zero flag
    flagEnable = 1'b1; zero = 1'b1; bzero = 1'b1;
    step();
    checks++; if (pc !== 10'd43) begin errors++; $display("FAIL bz_old_flag got %0d exp 43", pc); end
    flagEnable = 1'b0; zero = 1'b0;
    step();
    checks++; if (pc !== 10'd40) begin errors++; $display("FAIL bz_new_flag got %0d exp 40", pc); end
    bzero = 1'b0; flagEnable = 1'b1; negative = 1'b1; zero = 1'b0;
    step();
    flagEnable = 1'b0; negative = 1'b0; bnegative = 1'b1; mainAddress = 10'd100;
    step();
    checks++; if (pc !== 10'd100) begin errors++; $display("FAIL bn_taken got %0d exp 100", pc); end
    bnegative = 1'b0;
  endtask

  task automatic test_input();
    imem[5] = W_IN;
    imem[6] = W_IN;
    inputValid = 1'b0;
    jump = 1'b1; mainAddress = 10'd5;
    step();
    jump = 1'b0;
    #1;
    checks++; if (stall !== 1'b1 || instructionValid !== 1'b0 || inputAck !== 1'b0 || operation !== OP_IN) begin
      errors++; $display("FAIL in_stall got st=%b iv=%b ack=%b op=%b exp 1 0 0 %b", stall, instructionValid, inputAck, operation, OP_IN); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== 10'd5 || stall !== 1'b1) begin
        errors++; $display("FAIL in_hold got pc=%0d st=%b exp pc=5 st=1", pc, stall); end
    end
    inputValid = 1'b1;
    #1;
    checks++; if (inputAck !== 1'b1 || instructionValid !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL in_ack got ack=%b iv=%b st=%b exp 1 1 0", inputAck, instructionValid, stall); end
    step();
    checks++; if (pc !== 10'd6 || inputAck !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL in_second_stall got pc=%0d ack=%b st=%b exp pc=6 ack=0 st=1", pc, inputAck, stall); end
    step();
    checks++; if (pc !== 10'd6 || stall !== 1'b1) begin
      errors++; $display("FAIL in_held_key got pc=%0d st=%b exp pc=6 st=1", pc, stall); end
    inputValid = 1'b0;
    step();
    inputValid = 1'b1;
    #1;
    checks++; if (inputAck !== 1'b1) begin errors++; $display("FAIL in_rearm_ack got %b exp 1", inputAck); end
    step();
    checks++; if (pc !== 10'd7 || inputAck !== 1'b0) begin
      errors++; $display("FAIL in_done got pc=%0d ack=%b exp pc=7 ack=0", pc, inputAck); end
    inputValid = 1'b0;
  endtask

  task automatic test_halt();
    jump = 1'b1; mainAddress = 10'd9;
    step();
    jump = 1'b0; HLT = 1'b1;
    #1;
    checks++; if (instructionValid !== 1'b1) begin errors++; $display("FAIL hlt_commit got %b exp 1", instructionValid); end
    step();
    HLT = 1'b0;
    #1;
    checks++; if (halted !== 1'b1 || pc !== 10'd9 || instructionValid !== 1'b0 || operation !== OP_NOP || stall !== 1'b0) begin
      errors++; $display("FAIL halted_state got h=%b pc=%0d iv=%b op=%b st=%b exp 1 9 0 %b 0", halted, pc, instructionValid, operation, stall, OP_NOP); end
    step();
    checks++; if (halted !== 1'b1 || pc !== 10'd9) begin
      errors++; $display("FAIL halted_hold got h=%b pc=%0d exp 1 9", halted, pc); end
    resume = 1'b1;
    step();
    checks++; if (halted !== 1'b0 || pc !== 10'd10) begin
      errors++; $display("FAIL resume got h=%b pc=%0d exp 0 10", halted, pc); end
    step();
    checks++; if (halted !== 1'b0 || pc !== 10'd11) begin
      errors++; $display("FAIL resume_running got h=%b pc=%0d exp 0 11", halted, pc); end
    resume = 1'b0;
    // HLT outranks jump
    HLT = 1'b1; jump = 1'b1; mainAddress = 10'd300;
    step();
    HLT = 1'b0; jump = 1'b0;
    checks++; if (halted !== 1'b1 || pc !== 10'd11) begin
      errors++; $display("FAIL hlt_priority got h=%b pc=%0d exp 1 11", halted, pc); end
    resume = 1'b1;
    step();
    resume = 1'b0;
    checks++; if (pc !== 10'd12) begin errors++; $display("FAIL resume_wrap got %0d exp 12", pc); end
  endtask

  task automatic test_retire_and_abort();
    imem[5] = W_IN;
    imem[6] = W_ADD;
    inputValid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    step();                                  // BOOT -> RUN, no commit
    step();                                  // commit 1, pc 1
    jump = 1'b1; mainAddress = 10'd5;
    step();                                  // commit 2, pc 5
    jump = 1'b0;
    step();                                  // stall
    step();                                  // stall
    checks++; if (pc !== 10'd5 || retiredCount !== (RC_EN ? 32'd2 : 32'd0)) begin
      errors++; $display("FAIL rc_stall got pc=%0d rc=%0d exp pc=5 rc=%0d", pc, retiredCount, RC_EN ? 2 : 0); end
    inputValid = 1'b1;
    step();                                  // commit 3, pc 6
    inputValid = 1'b0;
    step();                                  // commit 4, pc 7
    HLT = 1'b1;
    step();                                  // commit 5, halted
    HLT = 1'b0;
    checks++; if (halted !== 1'b1 || retiredCount !== (RC_EN ? 32'd5 : 32'd0)) begin
      errors++; $display("FAIL rc_halt got h=%b rc=%0d exp h=1 rc=%0d", halted, retiredCount, RC_EN ? 5 : 0); end
    step();
    checks++; if (retiredCount !== (RC_EN ? 32'd5 : 32'd0)) begin
      errors++; $display("FAIL rc_halt_hold got %0d exp %0d", retiredCount, RC_EN ? 5 : 0); end
    resume = 1'b1;
    step();                                  // pc 8
    resume = 1'b0;
    jump = 1'b1; mainAddress = 10'd5;
    step();                                  // commit 6, pc 5 stalled
    jump = 1'b0;
    step();
    checks++; if (stall !== 1'b1 || retiredCount !== (RC_EN ? 32'd6 : 32'd0)) begin
      errors++; $display("FAIL rc_restall got st=%b rc=%0d exp st=1 rc=%0d", stall, retiredCount, RC_EN ? 6 : 0); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (pc !== 10'd0 || retiredCount !== 32'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL abort_regs got pc=%0d rc=%0d h=%b exp 0 0 0", pc, retiredCount, halted); end
    checks++; if ({stall, instructionValid, inputAck} !== 3'b000 || operation !== OP_NOP) begin
      errors++; $display("FAIL abort_strobes got %b op=%b exp 000 op=%b", {stall, instructionValid, inputAck}, operation, OP_NOP); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (instructionValid !== 1'b0 || pc !== 10'd0) begin
      errors++; $display("FAIL abort_boot got iv=%b pc=%0d exp 0 0", instructionValid, pc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) imem[i] = W_ADD;
    jump = 1'b0; bzero = 1'b0; bnegative = 1'b0; HLT = 1'b0;
    flagEnable = 1'b0; zero = 1'b0; negative = 1'b0;
    inputValid = 1'b0; resume = 1'b0; mainAddress = 10'd0;
    test_reset();
    test_wrap();
    test_branch();
    test_input();
    test_halt();
    test_retire_and_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
